// File: rtl/pattern_pkg.sv
// Shared record types and byte-stream helpers for the record serializer and
// the planned deserializer.
package pattern_pkg;

   localparam int unsigned REC_BYTES = 6;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned CNT_W     = 16;

   typedef logic [7:0] T;

   typedef struct packed {
      logic [7:0]  x;
      T            y;
      logic [31:0] z;
   } S;

   typedef enum logic [1:0] {
      FLD_X = 2'd0,
      FLD_Y = 2'd1,
      FLD_Z = 2'd2
   } field_t;

   // Byte presented on the stream for position idx of record s.
   function automatic logic [7:0] rec_byte(input S s, input logic [IDX_W-1:0] idx,
                                           input logic z_lsb_first);
      logic [31:0] w_zo;
      logic [1:0]  w_k;
      w_zo = z_lsb_first ? {s.z[7:0], s.z[15:8], s.z[23:16], s.z[31:24]} : s.z;
      w_k  = 2'(idx - 3'd2);
      case (idx)
         3'd0:    rec_byte = s.x;
         3'd1:    rec_byte = s.y;
         default: begin
            case (w_k)
               2'd0:    rec_byte = w_zo[31:24];
               2'd1:    rec_byte = w_zo[23:16];
               2'd2:    rec_byte = w_zo[15:8];
               default: rec_byte = w_zo[7:0];
            endcase
         end
      endcase
   endfunction

   // Field tag for stream position idx.
   function automatic field_t rec_field(input logic [IDX_W-1:0] idx);
      case (idx)
         3'd0:    rec_field = FLD_X;
         3'd1:    rec_field = FLD_Y;
         default: rec_field = FLD_Z;
      endcase
   endfunction

endpackage

// File: rtl/rec_serializer.sv
// Serializes one packed record per handshake into a six-byte tagged stream
// with an end-of-record marker and a completed-record counter.
module rec_serializer
   import pattern_pkg::*;
#(
   parameter bit Z_LSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  S            in_rec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [1:0]  out_field,
   output logic        out_last,
   output logic [15:0] rec_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   S                   r_hold;
   logic [CNT_W-1:0]   r_count;
   logic               w_accept;
   logic               w_xfer;
   logic               w_last;

   // Outputs decode only from registered state, index and holding register.
   assign w_last    = (r_state == ST_SEND) && (r_idx == LAST_IDX);
   assign w_xfer    = (r_state == ST_SEND) && out_ready;
   assign in_ready  = (r_state == ST_IDLE) || (w_xfer && w_last);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == ST_SEND);
   assign out_last  = w_last;
   assign out_data  = rec_byte(r_hold, r_idx, Z_LSB_FIRST);
   assign out_field = 2'(rec_field(r_idx));
   assign rec_count = r_count;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SEND;
               w_idx_nxt   = '0;
            end
         end
         ST_SEND: begin
            if (w_xfer) begin
               if (w_last) begin
                  // A same-cycle accept keeps the stream gapless.
                  w_state_nxt = w_accept ? ST_SEND : ST_IDLE;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
      end else if (w_accept) begin
         r_hold <= in_rec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_xfer && w_last) begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_rec_serializer.sv
// Bench for rec_serializer: two instances (MSB-first and LSB-first z) share
// stimulus and are checked every cycle against a queue-based record model.
module tb_rec_serializer;
   import pattern_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   S            in_rec;
   logic        out_ready;
   logic        in_ready_m, in_ready_l;
   logic        out_valid_m, out_valid_l;
   logic [7:0]  out_data_m, out_data_l;
   logic [1:0]  out_field_m, out_field_l;
   logic        out_last_m, out_last_l;
   logic [15:0] rec_count_m, rec_count_l;

   rec_serializer #(.Z_LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_rec(in_rec), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_data(out_data_m), .out_field(out_field_m), .out_last(out_last_m),
      .rec_count(rec_count_m));

   rec_serializer #(.Z_LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_rec(in_rec), .out_valid(out_valid_l), .out_ready(out_ready),
      .out_data(out_data_l), .out_field(out_field_l), .out_last(out_last_l),
      .rec_count(rec_count_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned tests;
   int unsigned fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each accepted record expands into six expected stream beats.
   typedef struct {
      logic [7:0] dm;
      logic [7:0] dl;
      logic [1:0] f;
      logic       l;
   } beat_t;

   beat_t       q[$];
   int unsigned m_count;
   int unsigned cycle;
   logic [7:0]  obs_m[$];
   logic [7:0]  obs_l[$];
   logic [1:0]  obs_f[$];
   logic        obs_last[$];
   int unsigned obs_cyc[$];

   function automatic beat_t mk_beat(input S r, input int k);
      beat_t b;
      logic [31:0] z;
      z = r.z;
      if (k == 0) begin
         b.dm = r.x; b.dl = r.x; b.f = 2'd0;
      end else if (k == 1) begin
         b.dm = r.y; b.dl = r.y; b.f = 2'd1;
      end else begin
         b.dm = 8'((z >> (8 * (5 - k))) & 32'hFF);
         b.dl = 8'((z >> (8 * (k - 2))) & 32'hFF);
         b.f  = 2'd2;
      end
      b.l = (k == 5);
      return b;
   endfunction

   always @(negedge clk) begin
      logic  e_ready;
      logic  xfer;
      beat_t b;
      if (rst) begin
         q.delete();
         m_count = 0;
      end else begin
         e_ready = (q.size() == 0);
         if (q.size() != 0) e_ready = out_ready && q[0].l;
         chk("in_ready_msb", 32'(in_ready_m), 32'(e_ready));
         chk("in_ready_lsb", 32'(in_ready_l), 32'(e_ready));
         chk("out_valid_msb", 32'(out_valid_m), 32'(q.size() != 0));
         chk("out_valid_lsb", 32'(out_valid_l), 32'(q.size() != 0));
         chk("rec_count_msb", 32'(rec_count_m), m_count);
         chk("rec_count_lsb", 32'(rec_count_l), m_count);
         xfer = 1'b0;
         if (q.size() != 0) begin
            b = q[0];
            chk("out_data_msb", 32'(out_data_m), 32'(b.dm));
            chk("out_data_lsb", 32'(out_data_l), 32'(b.dl));
            chk("out_field", 32'(out_field_m), 32'(b.f));
            chk("out_last", 32'(out_last_m), 32'(b.l));
            xfer = out_ready;
         end
         if (xfer) begin
            obs_m.push_back(out_data_m);
            obs_l.push_back(out_data_l);
            obs_f.push_back(out_field_m);
            obs_last.push_back(out_last_m);
            obs_cyc.push_back(cycle);
            if (q[0].l) m_count = (m_count + 1) % 65536;
            void'(q.pop_front());
         end
         if (in_valid && e_ready)
            for (int k = 0; k < 6; k++) q.push_back(mk_beat(in_rec, k));
      end
      cycle++;
   end

   task automatic clear_obs();
      obs_m.delete(); obs_l.delete(); obs_f.delete(); obs_last.delete(); obs_cyc.delete();
   endtask

   task automatic send(input S r);
      logic ok;
      in_valid = 1'b1;
      in_rec   = r;
      ok       = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready_m;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      logic busy;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      busy      = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
         @(negedge clk);
         busy = out_valid_m;
         @(posedge clk);
         #1;
      end
      if (busy) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_stream(input string name, input logic [7:0] got[$], input logic [47:0] exp);
      chk({name, "_len"}, 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         chk(name, 32'(got[i]), 32'(exp[47 - 8 * i -: 8]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      S r;
      tests = 0; fails = 0; m_count = 0; cycle = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_rec = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready_m), 32'd1);
      chk("rst_out_valid", 32'(out_valid_m), 32'd0);
      chk("rst_out_data", 32'(out_data_m), 32'd0);
      chk("rst_out_field", 32'(out_field_m), 32'd0);
      chk("rst_out_last", 32'(out_last_m), 32'd0);
      chk("rst_rec_count", 32'(rec_count_m), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;

      // Basic record, both z byte orders.
      clear_obs();
      send('{x: 8'h01, y: 8'h02, z: 32'd3});
      drain();
      chk_stream("basic_msb", obs_m, 48'h01_02_00_00_00_03);
      chk_stream("basic_lsb", obs_l, 48'h01_02_03_00_00_00);
      chk("basic_fields", 32'({obs_f[0], obs_f[1], obs_f[2], obs_f[5]}), 32'b00_01_10_10);
      chk("basic_last", 32'({obs_last[0], obs_last[4], obs_last[5]}), 32'b001);
      chk("basic_count", 32'(rec_count_m), 32'd1);

      clear_obs();
      send('{x: 8'd7, y: 8'd8, z: 32'd9});
      drain();
      chk_stream("order_lsb", obs_l, 48'h07_08_09_00_00_00);

      // Backpressure for three cycles at byte index 2.
      clear_obs();
      send('{x: 8'hFF, y: 8'h80, z: 32'hDEADBEEF});
      in_valid = 1'b1;
      in_rec   = '{x: 8'h11, y: 8'h22, z: 32'h33445566};
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_data", 32'(out_data_m), 32'hDE);
         chk("bp_in_ready", 32'(in_ready_m), 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      chk_stream("bp_stream", obs_m, 48'hFF_80_DE_AD_BE_EF);

      // Back-to-back records with continuous in_valid.
      clear_obs();
      send('{x: 8'd3, y: 8'd0, z: 32'd2});
      send('{x: 8'd5, y: 8'd4, z: 32'd2});
      drain();
      chk("b2b_beats", 32'(obs_cyc.size()), 32'd12);
      if (obs_cyc.size() == 12)
         chk("b2b_span", obs_cyc[11] - obs_cyc[0], 32'd11);
      chk("b2b_count", 32'(rec_count_m), 32'd5);

      // Reset during byte index 3.
      send('{x: 8'h12, y: 8'h34, z: 32'h56789ABC});
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid_m), 32'd0);
      chk("mid_rst_count", 32'(rec_count_m), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      send('{x: 8'hAA, y: 8'h55, z: 32'h01020304});
      drain();
      chk_stream("post_rst", obs_m, 48'hAA_55_01_02_03_04);
      chk("post_rst_count", 32'(rec_count_m), 32'd1);

      // Counter wrap from 16'hFFFF.
      @(posedge clk);
      #2;
      force u_msb.r_count = 16'hFFFF;
      force u_lsb.r_count = 16'hFFFF;
      #1;
      release u_msb.r_count;
      release u_lsb.r_count;
      m_count = 32'hFFFF;
      send('{x: 8'h01, y: 8'h01, z: 32'h1});
      drain();
      chk("wrap_count", 32'(rec_count_m), 32'd0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         rst       = ($urandom_range(0, 599) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         r.x = 8'($urandom);
         r.y = 8'($urandom);
         r.z = $urandom;
         in_rec = r;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rec_serializer.md
# rec_serializer

Transmit-side counterpart to the packed record assembly used in the pattern tests. It accepts one packed record S per valid/ready handshake: x (byte), y (T = byte) and z (integer, 32 bits), 48 bits total, with x in bits [47:40]. It emits the record as a six-byte stream with field tags and an end-of-record marker. It sits between any producer of S values and a byte-wide link or checker.

## Interface
- Z_LSB_FIRST, default 0, byte order of field z on the stream: 0 = most-significant byte first, 1 = least-significant byte first.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a record on in_rec.
- in_ready  output  1  block accepts in_rec this cycle.
- in_rec  input  48  packed S: {x[7:0], y[7:0], z[31:0]}.
- out_valid  output  1  out_data/out_field/out_last valid.
- out_ready  input  1  consumer accepts current byte.
- out_data  output  8  current byte.
- out_field  output  2  tag of the current byte: 0 = x, 1 = y, 2 = z; 3 is never driven.
- out_last  output  1  high on the sixth (final) byte of a record.
- rec_count  output  16  records fully sent; wraps at 16'hFFFF → 0.

## Operation
- States:
  - IDLE: no record held; out_valid = 0.
  - SEND: a record is held; out_valid = 1; a 3-bit byte index idx runs 0..5.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is combinational from registered state and out_ready.
- An accept occurs when in_valid && in_ready. On accept:
  - in_rec is latched into a 48-bit holding register.
  - idx ← 0 and state ← SEND.
- Byte mapping:
  - idx 0 → x, field 0.
  - idx 1 → y, field 1.
  - idx 2..5 → z bytes, field 2. z byte k = idx-2 is z[31-8k -: 8] when Z_LSB_FIRST = 0, else z[8k +: 8].
- Transfer: out_valid && out_ready. On a transfer with idx < 5, idx increments.
- On a transfer with idx == 5 (out_last = 1):
  - rec_count increments (mod 2^16).
  - If a new accept occurs in the same cycle, stay in SEND with idx ← 0.
  - Otherwise go to IDLE.
- While out_valid && !out_ready, out_data, out_field and out_last hold stable.
- in_rec is ignored except on an accept cycle. The producer may change it freely otherwise.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 8'h00, out_field 0, out_last 0, rec_count 0, holding register 0.
- Latency: accept at edge N → byte 0 presented after edge N (visible cycle N+1).
- Throughput: one byte per cycle with out_ready held high. Back-to-back records stream with no idle cycle (6 cycles/record).
- out_data/out_field/out_last are registered or decoded from registered idx and the holding register only. There is no combinational path from in_rec to the outputs.
- Reset mid-record: the record is discarded and rec_count is cleared. The first cycle after rst deasserts is IDLE with in_ready = 1.
- in_valid high in SEND before the last transfer: no accept; the producer must hold the record.

## Structure
- Shared package pattern_pkg:
  - typedef T (byte).
  - typedef S (packed struct: byte x, T y, integer z).
  - enum field_t {FLD_X = 0, FLD_Y = 1, FLD_Z = 2} as 2-bit.
  - localparam REC_BYTES = 6.
  - function rec_byte(S s, idx, z_lsb_first) returning 8 bits.
- in_rec is declared as pattern_pkg::S. Fields are referenced by name (s.x, s.y, s.z), never by bit slices.
- No sub-module: one FSM/datapath module. A matching rec_deserializer is planned later and reuses pattern_pkg.

## Test plan
- Basic: Z_LSB_FIRST = 0, record '{x:1, y:2, z:3}, out_ready = 1 → bytes 01,02,00,00,00,03; fields 0,1,2,2,2,2; out_last only on byte 6; rec_count = 1.
- Byte order: Z_LSB_FIRST = 1, record '{1:8, 2:9, 0:7} (x = 7, y = 8, z = 9) → 07,08,09,00,00,00.
- Backpressure: record {FF, 80, DEADBEEF}; out_ready low for 3 cycles at idx 2 → DE held stable throughout; full stream FF,80,DE,AD,BE,EF; in_ready stays 0 until the last transfer.
- Back-to-back: records '{integer:2, byte:3} then '{integer:2, T:4, byte:5}, in_valid continuous → 12 bytes in 12 consecutive cycles; second accept coincides with the first out_last; rec_count = 2.
- Reset mid-record: assert rst during idx 3 → out_valid 0 and rec_count 0 immediately; after release a fresh record {AA, 55, 01020304} streams correctly from byte 0.
- Wrap: preload via 65535 records (or force) → the 65536th completion sets rec_count to 0.
